// File: rtl/inst_loader_pkg.sv
// Shared types and widths for the instruction loader.
package inst_loader_pkg;

    // Position of the next byte inside the 32-bit word being assembled.
    localparam int BYTE_IDX_W = 2;

    // Width of the word count carried in the stream header.
    localparam int WORD_CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/inst_loader_shifter.sv
// Byte-to-word assembler: bytes arrive MSB first and are shifted in from the
// right; word_next already contains the byte being accepted this cycle.
module inst_loader_shifter
    import inst_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    output logic [31:0]           word_next,
    output logic [BYTE_IDX_W-1:0] byte_idx,
    output logic                  word_ready
);

    logic [31:0]           word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic                  ready_q, ready_d;

    assign word_next  = {word_q[23:0], byte_in};
    assign byte_idx   = idx_q;
    assign word_ready = ready_q;

    // Shift one byte per accepted transfer; index wraps 3 -> 0 on its own.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        ready_d = 1'b0;
        if (clear) begin
            idx_d = '0;
        end else if (shift_en) begin
            word_d  = word_next;
            idx_d   = idx_q + 1'b1;
            ready_d = &idx_q;
        end
    end

    // Control state: byte index and the one-cycle word-complete flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    // Datapath shift register; every word is fully rebuilt from 4 bytes.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: receives "count (4 bytes) + count words (MSB first)"
// from a byte stream and writes the words into instruction RAM while holding
// the CPU in reset. Optional inter-byte timeout: INST_LOADER_TIMEOUT_EN.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        debug,
    output logic        inst_ram_write_enable,
    output logic [31:0] inst_ram_write_data,
    output logic [31:0] inst_ram_write_address,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [WORD_CNT_W-1:0] MAX_CNT = WORD_CNT_W'(MAX_WORDS);

    if (MAX_WORDS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("inst_loader: MAX_WORDS and TIMEOUT_CYCLES must be positive");
    end

    state_t                state_q, state_d;
    logic [WORD_CNT_W-1:0] remain_q, remain_d;
    logic [31:0]           next_addr_q, next_addr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  xfer;
    logic                  sess_closed;
    logic                  start_ok;
    logic                  last_byte;
    logic                  word_ready;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [31:0]           word_next;

`ifdef INST_LOADER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
`endif

    // in_ready depends on state only, never on in_valid.
    assign in_ready    = (state_q == HDR) || (state_q == DATA);
    assign xfer        = in_valid && in_ready;
    assign sess_closed = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
    assign start_ok    = load_start && !xfer && sess_closed;
    assign last_byte   = xfer && (&byte_idx);

    inst_loader_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .shift_en   (xfer),
        .byte_in    (in_data),
        .word_next  (word_next),
        .byte_idx   (byte_idx),
        .word_ready (word_ready)
    );

    // Next-state, word bookkeeping and write capture.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        next_addr_d = next_addr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_ok) begin
                    state_d     = HDR;
                    next_addr_d = BASE_ADDR;
                end
            end
            HDR: begin
                if (last_byte) begin
                    if (word_next == '0) begin
                        state_d = DONE;
                    end else if (word_next > MAX_CNT) begin
                        state_d = ERR;
                    end else begin
                        state_d  = DATA;
                        remain_d = word_next;
                    end
                end
            end
            DATA: begin
                if (last_byte) begin
                    state_d     = WRITE;
                    wdata_d     = word_next;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + 32'd4;
                    remain_d    = remain_q - 1'b1;
                end
            end
            WRITE: begin
                state_d = (remain_q == '0) ? DONE : DATA;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef INST_LOADER_TIMEOUT_EN
        // Idle-gap counter: only runs while waiting for a byte.
        tmo_d = '0;
        if (in_ready && !xfer) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ERR;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
    end

    // State, counters and held write outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            next_addr_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            next_addr_q <= next_addr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef INST_LOADER_TIMEOUT_EN
    // Timeout counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign debug                  = in_ready || (state_q == WRITE);
    assign inst_ram_write_enable  = (state_q == WRITE) && word_ready;
    assign inst_ram_write_data    = wdata_q;
    assign inst_ram_write_address = addr_q;
    assign cpu_reset              = (state_q != DONE);
    assign load_done              = (state_q == DONE);
    assign load_error             = (state_q == ERR);

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first loaded word.
REQ-003 Parameter MAX_WORDS, default 1024, is the largest accepted word count.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_000_000, is the allowed idle gap between bytes.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset  in  1  asynchronous reset, active-low.
REQ-007 load_start  in  1  one-cycle pulse; begins a load session.
REQ-008 in_valid  in  1  byte-stream valid from the UART receiver.
REQ-009 in_data  in  8  byte-stream payload.
REQ-010 in_ready  out  1  byte-stream ready; a byte transfers when in_valid && in_ready.
REQ-011 debug  out  1  selects the loader address into the instruction RAM.
REQ-012 inst_ram_write_enable  out  1  one-cycle word write strobe.
REQ-013 inst_ram_write_data  out  32  word to write.
REQ-014 inst_ram_write_address  out  32  byte address of the word.
REQ-015 cpu_reset  out  1  active-high hold for the CPU core.
REQ-016 load_done  out  1  level; the last session completed successfully.
REQ-017 load_error  out  1  level; the last session aborted.

Function
REQ-018 Stream format SHALL be 4 count bytes then count x 4 data bytes, MSB first.
REQ-019 FSM states SHALL be IDLE, HDR, DATA, WRITE, DONE and ERR.
  - IDLE -> HDR on load_start.
  - HDR -> DATA after the 4th count byte.
  - HDR -> DONE if count == 0.
  - HDR -> ERR if count > MAX_WORDS.
  - DATA -> WRITE after the 4th data byte.
  - WRITE -> DATA if words remain, else DONE.
  - DONE and ERR -> HDR on load_start.
REQ-020 in_ready SHALL be 1 only in HDR and DATA, with no combinational path from in_valid.
REQ-021 The byte counter SHALL wrap 3 -> 0 and the shift register SHALL shift left 8 bits per accepted byte.
REQ-022 inst_ram_write_enable SHALL be high for exactly the single WRITE cycle, one cycle after the 4th data byte is accepted.
REQ-023 Word k (0-based) SHALL be written to address BASE_ADDR + 4*k, computed modulo 2^32.
REQ-024 inst_ram_write_data and inst_ram_write_address SHALL hold their last values outside WRITE.
REQ-025 debug SHALL be 1 in HDR, DATA and WRITE, and 0 otherwise.
REQ-026 cpu_reset SHALL be 1 in every state except DONE, and SHALL fall on entry to DONE.
REQ-027 load_done SHALL be 1 only in DONE, and load_error SHALL be 1 only in ERR.
REQ-028 Both load_done and load_error SHALL clear on leaving their state.
REQ-029 load_start SHALL be ignored in HDR, DATA and WRITE.
REQ-030 A load_start arriving in the same cycle as a byte transfer SHALL be ignored.
REQ-031 Throughput SHALL be one word per 5 cycles when in_valid is held high.

Reset
REQ-032 Asserting reset at any time, including mid-session, SHALL force state IDLE and clear all counters.
REQ-033 The reset values of the outputs SHALL be: in_ready 0, debug 0, write_enable 0, data and address 0, cpu_reset 1, load_done 0, load_error 0.
REQ-034 A partial word in progress at reset SHALL be discarded and never written.

Configuration
REQ-035 The macro INST_LOADER_TIMEOUT_EN SHALL control the inter-byte timeout.
REQ-036 With INST_LOADER_TIMEOUT_EN defined:
  - A counter SHALL run in HDR and DATA and clear on every accepted byte.
  - When it reaches TIMEOUT_CYCLES the FSM SHALL go to ERR.
REQ-037 Without INST_LOADER_TIMEOUT_EN, no timeout counter SHALL exist and HDR/DATA SHALL wait indefinitely.

Structure
REQ-038 The shared package inst_loader_pkg SHALL hold:
  - the state enum;
  - the byte-index width, 2 bits;
  - the word-count width, 32 bits.
REQ-039 A sub-module inst_loader_shifter (8-bit in, 32-bit out, byte index, word-ready flag) SHALL perform the byte-to-word assembly.
REQ-040 The FSM, address counter and timeout SHALL stay in inst_loader.

Verification
REQ-041 Load 2 words (stream 00 00 00 02 | 24 08 00 05 | 00 00 00 00) -> two write strobes: addr 0x0 data 0x24080005, then addr 0x4 data 0x00000000.
  - debug falls and cpu_reset falls after the second write; load_done = 1.
REQ-042 Count 0 -> DONE right after the 4th header byte, no write strobe, cpu_reset = 0.
REQ-043 Count MAX_WORDS+1 -> ERR, load_error = 1, no write strobe, cpu_reset stays 1.
REQ-044 Assert reset after 2 data bytes of word 0 -> IDLE, no write, then a fresh 1-word load writes address 0x0 correctly.
REQ-045 With INST_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, stall 16 cycles after header byte 2 -> ERR.
  - The same test without the macro -> still in HDR after 1000 cycles.
REQ-046 Random in_valid gaps during a 64-word load -> all 64 words written at 4-byte strides with data matching, and no byte is accepted while in_ready = 0.
